ccta_sched: RTL and testbench

- Scheduler that shares one combinational CCTA datapath (4-bit A/B/C operands, ctrl select, 5-bit q result) between two requesters.
- Arbitrates, registers the winning operand set, and drives the CCTA inputs for a programmable settle time.
- Samples q, then returns it on a valid/ready response channel tagged with the requester id.
- Sits between the requester logic and the CCTA instance. The CCTA stays unchanged and is instantiated beside this block.

---
 rtl/ccta_sched.sv | 168 ++++++++++++++++
 tb/tb_ccta_sched.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ccta_sched.sv
// Two-requester scheduler in front of a shared combinational CCTA: arbitrate, hold operands, sample q, respond.
// Build option CCTA_SCHED_PRIO_EN: fixed priority to requester 0 instead of round-robin.
module ccta_sched #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req0_c,
    input  logic             req0_ctrl,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [WIDTH-1:0] req1_c,
    input  logic             req1_ctrl,
    output logic             ccta_rst,
    output logic [WIDTH-1:0] ccta_a,
    output logic [WIDTH-1:0] ccta_b,
    output logic [WIDTH-1:0] ccta_c,
    output logic             ccta_ctrl,
    input  logic [WIDTH:0]   ccta_q,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH:0]   rsp_q,
    output logic             rsp_id,
    output logic             busy
);

    localparam int unsigned CNT_W      = 4;
    localparam int unsigned SETTLE_EFF = (SETTLE == 0) ? 1 : SETTLE;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_EFF - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
    logic               ctrl_q, ctrl_d;
    logic               id_q, id_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [WIDTH:0]     rsp_data_q, rsp_data_d;
    logic               ccta_rst_q, ccta_rst_d;
    logic               busy_q, busy_d;
    logic               gnt_any, gnt_id, hs_idle;

    // Arbitration: a lone requester always wins; contention follows the build's policy
`ifdef CCTA_SCHED_PRIO_EN
    assign gnt_id = ~req0_valid;
`else
    logic last_id_q, last_id_d;
    assign gnt_id = (req0_valid && req1_valid) ? ~last_id_q : req1_valid;
`endif
    assign gnt_any    = req0_valid | req1_valid;
    assign hs_idle    = (state_q == S_IDLE) && gnt_any;
    assign req0_ready = rst_n && hs_idle && !gnt_id;
    assign req1_ready = rst_n && hs_idle && gnt_id;

    // Next-state and register-update logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        ctrl_d      = ctrl_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        ccta_rst_d  = ccta_rst_q;
        busy_d      = busy_q;
`ifndef CCTA_SCHED_PRIO_EN
        last_id_d   = last_id_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (gnt_any) begin
                    a_d        = gnt_id ? req1_a : req0_a;
                    b_d        = gnt_id ? req1_b : req0_b;
                    c_d        = gnt_id ? req1_c : req0_c;
                    ctrl_d     = gnt_id ? req1_ctrl : req0_ctrl;
                    id_d       = gnt_id;
                    cnt_d      = CNT_LOAD;
                    ccta_rst_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = S_ISSUE;
`ifndef CCTA_SCHED_PRIO_EN
                    last_id_d  = gnt_id;
`endif
                end
            end
            S_ISSUE: begin
                if (cnt_q == '0) begin
                    rsp_data_d  = ccta_q;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    ccta_rst_d  = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            ctrl_q      <= 1'b0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            ccta_rst_q  <= 1'b1;
            busy_q      <= 1'b0;
`ifndef CCTA_SCHED_PRIO_EN
            last_id_q   <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            ctrl_q      <= ctrl_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            ccta_rst_q  <= ccta_rst_d;
            busy_q      <= busy_d;
`ifndef CCTA_SCHED_PRIO_EN
            last_id_q   <= last_id_d;
`endif
        end
    end

    assign ccta_rst  = ccta_rst_q;
    assign ccta_a    = a_q;
    assign ccta_b    = b_q;
    assign ccta_c    = c_q;
    assign ccta_ctrl = ctrl_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_q     = rsp_data_q;
    assign rsp_id    = id_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ccta_sched.sv
// Bench for ccta_sched: two instances (SETTLE=1 and SETTLE=3), each beside a CCTA model whose q is only
// correct once operands have been stable for SETTLE cycles; transactions are predicted at the protocol level.
module tb_ccta_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic [1:0][1:0]      rv, rrdy, rctl;
    logic [1:0][1:0][3:0] ra, rb, rc;
    logic [1:0]           ccta_rst, ccta_ctrl, rsp_valid, rsp_ready, rsp_id, busy;
    logic [1:0][3:0]      ccta_a, ccta_b, ccta_c;
    logic [1:0][4:0]      ccta_q, rsp_q;

    int n_chk  = 0;
    int n_pass = 0;

    function automatic logic [4:0] ccta_f(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] c, input logic ctl);
        return ctl ? (5'(a ^ c) + 5'(b)) : (5'(a) + 5'(b));
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_dut
        localparam int SET = (k == 0) ? 1 : 3;
        logic [13:0] cur, prev_q;
        int age, age_q;

        ccta_sched #(.WIDTH(4), .SETTLE(SET)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .req0_valid(rv[k][0]), .req0_ready(rrdy[k][0]),
            .req0_a(ra[k][0]), .req0_b(rb[k][0]), .req0_c(rc[k][0]), .req0_ctrl(rctl[k][0]),
            .req1_valid(rv[k][1]), .req1_ready(rrdy[k][1]),
            .req1_a(ra[k][1]), .req1_b(rb[k][1]), .req1_c(rc[k][1]), .req1_ctrl(rctl[k][1]),
            .ccta_rst(ccta_rst[k]), .ccta_a(ccta_a[k]), .ccta_b(ccta_b[k]), .ccta_c(ccta_c[k]),
            .ccta_ctrl(ccta_ctrl[k]), .ccta_q(ccta_q[k]),
            .rsp_valid(rsp_valid[k]), .rsp_ready(rsp_ready[k]), .rsp_q(rsp_q[k]),
            .rsp_id(rsp_id[k]), .busy(busy[k])
        );

        // CCTA model: output is wrong until inputs have been stable for SET cycles
        assign cur = {ccta_rst[k], ccta_ctrl[k], ccta_a[k], ccta_b[k], ccta_c[k]};
        always_comb age = (cur != prev_q) ? 1 : ((age_q < 15) ? age_q + 1 : 15);
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                prev_q <= '0;
                age_q  <= 0;
            end else begin
                prev_q <= cur;
                age_q  <= age;
            end
        end
        assign ccta_q[k] = (!ccta_rst[k] && age >= SET)
                         ? ccta_f(ccta_a[k], ccta_b[k], ccta_c[k], ccta_ctrl[k])
                         : ~ccta_f(ccta_a[k], ccta_b[k], ccta_c[k], ccta_ctrl[k]);
    end

    // Reference model state: pending requests per instance/requester and the last grant
    logic       pend[2][2];
    logic [3:0] pa[2][2], pb[2][2], pc[2][2];
    logic       pctl[2][2];
    int         last[2];

    function automatic int settle_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s inst%0d observed=%0h expected=%0h", tag, k, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            last[k] = 1;
            for (int r = 0; r < 2; r++) pend[k][r] = 1'b0;
        end
    endtask

    task automatic drive_reqs(input int k);
        for (int r = 0; r < 2; r++) begin
            rv[k][r]   = pend[k][r];
            ra[k][r]   = pa[k][r];
            rb[k][r]   = pb[k][r];
            rc[k][r]   = pc[k][r];
            rctl[k][r] = pctl[k][r];
        end
    endtask

    task automatic set_req(input int k, input int r, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic ctl);
        pend[k][r] = 1'b1;
        pa[k][r] = a;
        pb[k][r] = b;
        pc[k][r] = c;
        pctl[k][r] = ctl;
    endtask

    // One full transaction from the IDLE grant through the response handshake
    task automatic run_txn(input int k, input int hold);
        int w;
        logic [3:0] ea, eb, ec;
        logic ectl;
        logic [4:0] eq;
        drive_reqs(k);
        rsp_ready[k] = 1'($urandom % 2);
        #1;
        if (pend[k][0] && pend[k][1]) begin
`ifdef CCTA_SCHED_PRIO_EN
            w = 0;
`else
            w = 1 - last[k];
`endif
        end else begin
            w = pend[k][1] ? 1 : 0;
        end
        chk("idle_ready", k, 32'(rrdy[k]), (w == 0) ? 32'd1 : 32'd2);
        chk("idle_busy", k, 32'(busy[k]), 32'd0);
        chk("idle_ccta_rst", k, 32'(ccta_rst[k]), 32'd1);
        chk("idle_rsp_valid", k, 32'(rsp_valid[k]), 32'd0);
        ea = pa[k][w]; eb = pb[k][w]; ec = pc[k][w]; ectl = pctl[k][w];
        eq = ccta_f(ea, eb, ec, ectl);
        @(posedge clk);
        pend[k][w] = 1'b0;
        last[k] = w;
        @(negedge clk);
        pa[k][w] = 4'($urandom); pb[k][w] = 4'($urandom); pc[k][w] = 4'($urandom);
        pctl[k][w] = 1'($urandom);
        drive_reqs(k);
        for (int i = 0; i < settle_of(k); i++) begin
            rsp_ready[k] = 1'($urandom % 2);
            #1;
            chk("issue_busy", k, 32'(busy[k]), 32'd1);
            chk("issue_ccta_rst", k, 32'(ccta_rst[k]), 32'd0);
            chk("issue_ops", k, 32'({ccta_ctrl[k], ccta_a[k], ccta_b[k], ccta_c[k]}),
                32'({ectl, ea, eb, ec}));
            chk("issue_rsp_valid", k, 32'(rsp_valid[k]), 32'd0);
            chk("issue_ready", k, 32'(rrdy[k]), 32'd0);
            tick();
        end
        for (int h = 0; h <= hold; h++) begin
            rsp_ready[k] = (h == hold);
            #1;
            chk("resp_valid", k, 32'(rsp_valid[k]), 32'd1);
            chk("resp_q", k, 32'(rsp_q[k]), 32'(eq));
            chk("resp_id", k, 32'(rsp_id[k]), 32'(w));
            chk("resp_busy", k, 32'(busy[k]), 32'd1);
            chk("resp_ready", k, 32'(rrdy[k]), 32'd0);
            tick();
        end
        rsp_ready[k] = 1'b0;
        #1;
        chk("post_busy", k, 32'(busy[k]), 32'd0);
        chk("post_rsp_valid", k, 32'(rsp_valid[k]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        rv = '1; rctl = '0; ra = '1; rb = '1; rc = '1;
        rsp_ready = '1;
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 2; r++) begin
                pa[k][r] = '0; pb[k][r] = '0; pc[k][r] = '0; pctl[k][r] = 1'b0;
            end
        model_reset();

        // Reset with both requesters valid
        tick(); tick();
        for (int k = 0; k < 2; k++) begin
            chk("rst_ready", k, 32'(rrdy[k]), 32'd0);
            chk("rst_rsp_valid", k, 32'(rsp_valid[k]), 32'd0);
            chk("rst_rsp_q", k, 32'(rsp_q[k]), 32'd0);
            chk("rst_rsp_id", k, 32'(rsp_id[k]), 32'd0);
            chk("rst_ccta_ops", k, 32'({ccta_ctrl[k], ccta_a[k], ccta_b[k], ccta_c[k]}), 32'd0);
            chk("rst_ccta_rst", k, 32'(ccta_rst[k]), 32'd1);
            chk("rst_busy", k, 32'(busy[k]), 32'd0);
        end
        rv = '0; rsp_ready = '0;
        rst_n = 1'b1;
        tick();

        // Single request, SETTLE=1
        set_req(0, 0, 4'h4, 4'h1, 4'h9, 1'b0);
        run_txn(0, 0);

        // Reset asserted in the middle of ISSUE
        set_req(1, 0, 4'hA, 4'h3, 4'h7, 1'b1);
        drive_reqs(1);
        tick();
        pend[1][0] = 1'b0;
        drive_reqs(1);
        chk("midrst_pre_busy", 1, 32'(busy[1]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 1, 32'(busy[1]), 32'd0);
        chk("midrst_ccta_rst", 1, 32'(ccta_rst[1]), 32'd1);
        chk("midrst_ccta_a", 1, 32'(ccta_a[1]), 32'd0);
        chk("midrst_rsp_valid", 1, 32'(rsp_valid[1]), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("midrst_no_rsp", 1, 32'(rsp_valid[1]), 32'd0);
        end

        // Continuous contention after reset
        for (int i = 0; i < 4; i++) begin
            set_req(0, 1, 4'hD, 4'h6, 4'hD, 1'b0);
            set_req(0, 0, 4'h6, 4'h5, 4'hA, 1'b1);
            run_txn(0, 0);
        end

        // Back-pressure in RESP while the other requester waits, then it gets served
        set_req(0, 0, 4'h2, 4'h9, 4'h1, 1'b0);
        if (!pend[0][1]) set_req(0, 1, 4'hD, 4'h6, 4'hD, 1'b0);
        run_txn(0, 5);
        run_txn(0, 0);

        // SETTLE=3 on requester 1
        set_req(1, 1, 4'hF, 4'h2, 4'hE, 1'b1);
        run_txn(1, 0);

        // Randomized traffic
        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 25; n++) begin
                for (int r = 0; r < 2; r++)
                    if (!pend[k][r] && ($urandom % 2) == 1)
                        set_req(k, r, 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
                if (!pend[k][0] && !pend[k][1])
                    set_req(k, int'($urandom % 2), 4'($urandom), 4'($urandom), 4'($urandom),
                            1'($urandom));
                run_txn(k, int'($urandom % 3));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
